// File: rtl/dispatch_pkg.sv
// Shared dispatch definitions: payload width, default queue depth and the packed
// dispatch payload layout carried through the instruction FIFO.
package dispatch_pkg;

  localparam int DISPATCH_PAYLOAD_W     = 128;
  localparam int DISPATCH_DEPTH_DEFAULT = 4;

  // Field widths sum to DISPATCH_PAYLOAD_W; pc occupies the top bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [23:0] src_a;
    logic [23:0] src_b;
    logic [5:0]  dst_rob;
    logic [19:0] imm;
    logic [3:0]  fid;
    logic [1:0]  pipe_sel;
    logic [7:0]  cmds;
    logic [7:0]  bp_info;
  } dispatch_payload_t;

endpackage

// File: rtl/dispatch_ififo_mem.sv
// Entry storage for the dispatch FIFO: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module dispatch_ififo_mem #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 128,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dispatch_ififo.sv
// Dispatch instruction FIFO with branch-commit flush. Defining DISPATCH_IFIFO_BYPASS_EN
// lets an entry arriving at an empty queue go straight to the consumer in the same cycle.
module dispatch_ififo
  import dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = DISPATCH_PAYLOAD_W,
  parameter int DEPTH      = DISPATCH_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bco_valid,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  bypass;
  logic                  push;
  logic                  pop;

  assign empty   = (count == '0);
  assign i_ready = !reset && !bco_valid && (count < CW'(DEPTH));

`ifdef DISPATCH_IFIFO_BYPASS_EN
  assign bypass  = !reset && !bco_valid && empty && i_valid && o_ready;
  assign o_valid = (!empty && !bco_valid) || bypass;
  assign o_data  = bypass ? i_data : rd_data;
`else
  assign bypass  = 1'b0;
  assign o_valid = !empty && !bco_valid;
  assign o_data  = rd_data;
`endif

  // A bypassed entry is consumed directly and never touches storage or the count.
  assign push = i_valid && i_ready && !bypass;
  assign pop  = o_valid && o_ready && !bypass;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bco_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_count = count;

  dispatch_ififo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (i_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule
